sram_bus_ctrl: RTL and testbench
================================

SRAM_BUS_CTRL -- requirements
Module: sram_bus_ctrl

Interface
REQ-001 Parameter DW, default 8: data width in bits, min 8.
REQ-002 Parameter AW, default 8: address width in bits, min 8.
REQ-003 Parameter WAIT_CYC, default 1: ACCESS-state cycles per beat, range 1..15.
REQ-004 Parameter TURN_CYC, default 1: HOLD-state bus-turnaround cycles, range 1..7.
REQ-005 Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  transfer request.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr_in  input  AW  start address.
- wdata  input  DW  write data.
- ready  output  1  controller idle, can accept req.
- ack  output  1  one-cycle pulse per completed beat.
- rdata  output  DW  read data, valid while ack=1 and held until next read ack.
- addr  output  AW  SRAM address.
- cen  output  1  chip enable, active-low.
- wen  output  1  write enable, active-low.
- oen  output  1  output enable, active-low.
- dq  inout  DW  SRAM data bus, tri-stated when not writing.

Function
REQ-006 FSM states: IDLE, SETUP, ACCESS, HOLD; encoding is binary.
REQ-007 ready=1 only in IDLE; req sampled only when ready=1; req while busy is ignored, not queued.
REQ-008 Accept edge: IDLE with req=1 latches we, addr_in, wdata and moves to SETUP.
REQ-009 SETUP lasts 1 cycle: addr driven, cen=0, wen=1, oen=1; dq driven with the latched wdata for writes, Z for reads.
REQ-010 ACCESS lasts WAIT_CYC cycles via a down-counter: cen=0; read has oen=0; write has wen=0 and dq driven.
REQ-011 Read data is captured into rdata on the final ACCESS clock edge.
REQ-012 HOLD lasts TURN_CYC cycles: cen=wen=oen=1, dq=Z, addr held.
REQ-013 ack pulses high for exactly the first HOLD cycle.
REQ-014 HOLD returns to IDLE after its last cycle.
REQ-015 Single-beat latency from accept edge to ack high is 1+WAIT_CYC cycles.
REQ-016 Back-to-back: the next req is accepted in the first IDLE cycle after HOLD; there are no combinational req->ready paths.
REQ-017 wen and oen are never low simultaneously; dq is never driven while oen=0.
REQ-018 addr_in/wdata changes after the accept edge have no effect on the current beat.

Reset
REQ-019 rst=0 asynchronously forces: IDLE, ready=1, ack=0, cen=wen=oen=1, dq=Z, addr=0, rdata=0, counters=0.
REQ-020 Reset mid-transfer aborts the transfer with no ack and deasserts all strobes in the same instant.
REQ-021 After reset release, the first req is accepted on the first rising edge with rst=1.

Configuration
REQ-022 Macro SRAM_BUS_CTRL_BURST_EN compiled in adds input burst_len [3:0], sampled at accept, giving beats = burst_len+1.
REQ-023 Burst sequencing: after each beat's HOLD, go to SETUP with addr+1, wrapping modulo 2^AW; one ack per beat.
REQ-024 Burst writes: wdata for beat n+1 is sampled on the edge where beat n's ack=1.
REQ-025 Macro absent: no burst_len port; every transfer is a single beat.

Structure
REQ-026 Shared package sram_bus_pkg holds the FSM state typedef, the state encodings, and the parameter range constants.
REQ-027 One sub-module, sram_bus_timer, provides the loadable down-counter used for both ACCESS and HOLD durations.

Verification
REQ-028 WAIT_CYC=1, TURN_CYC=1:
- Write 0xA5 to 0x3C: wen=0 for 1 cycle with dq=0xA5 and addr=0x3C; ack 2 cycles after accept.
- Then read 0x3C (SRAM model returns 0xA5): oen=0 for 1 cycle, rdata=0xA5 with ack.
REQ-029 WAIT_CYC=3: read 0x00 -> oen low 3 cycles, ack 4 cycles after accept; req held high during busy gives no second accept until IDLE.
REQ-030 Reset asserted during ACCESS of write 0x55@0x10 -> cen/wen high and dq=Z immediately, no ack, ready=1.
REQ-031 BURST_EN, burst_len=3, read from 0xFE, AW=8 -> addrs 0xFE, 0xFF, 0x00, 0x01, four acks.
REQ-032 Every scenario runs a continuous assertion: no cycle with wen=0 and oen=0, and no dq drive during oen=0.

Source files
------------

// File: rtl/sram_bus_pkg.sv
// sram_bus_pkg: shared FSM state type, counter width and parameter range limits
package sram_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int CNT_W    = 4;
    localparam int BURST_W  = 4;
    localparam int DW_MIN   = 8;
    localparam int AW_MIN   = 8;
    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;
    localparam int TURN_MIN = 1;
    localparam int TURN_MAX = 7;

    function automatic logic [CNT_W-1:0] cnt_val(input int v, input int lo, input int hi);
        return CNT_W'(v < lo ? lo : (v > hi ? hi : v));
    endfunction

endpackage

// File: rtl/sram_bus_timer.sv
// sram_bus_timer: loadable down-counter timing the ACCESS and HOLD phases
module sram_bus_timer
    import sram_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    // load wins; otherwise count down and rest at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - CNT_W'(1);
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/sram_bus_ctrl.sv
// sram_bus_ctrl: asynchronous SRAM bus controller (optional burst mode via SRAM_BUS_CTRL_BURST_EN)
module sram_bus_ctrl
    import sram_bus_pkg::*;
#(
    parameter int DW       = 8,
    parameter int AW       = 8,
    parameter int WAIT_CYC = 1,
    parameter int TURN_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               we,
    input  logic [AW-1:0]      addr_in,
    input  logic [DW-1:0]      wdata,
`ifdef SRAM_BUS_CTRL_BURST_EN
    input  logic [BURST_W-1:0] burst_len,
`endif
    output logic               ready,
    output logic               ack,
    output logic [DW-1:0]      rdata,
    output logic [AW-1:0]      addr,
    output logic               cen,
    output logic               wen,
    output logic               oen,
    inout  wire  [DW-1:0]      dq
);

    localparam logic [CNT_W-1:0] WAIT_LD = cnt_val(WAIT_CYC, WAIT_MIN, WAIT_MAX);
    localparam logic [CNT_W-1:0] TURN_LD = cnt_val(TURN_CYC, TURN_MIN, TURN_MAX);

    state_t           state;
    state_t           state_nxt;
    logic             we_q;
    logic [DW-1:0]    wdata_q;
    logic [CNT_W-1:0] count;
    logic             last;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             accept;
    logic             more;
    logic             dq_drv;

    sram_bus_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .last     (last)
    );

    assign accept = ready && req;

`ifdef SRAM_BUS_CTRL_BURST_EN
    logic [BURST_W-1:0] beats_left;

    assign more = (beats_left != '0);

    // remaining beats: loaded at accept, consumed at the end of each HOLD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            beats_left <= '0;
        else if (accept)
            beats_left <= burst_len;
        else if (state == HOLD && last && more)
            beats_left <= beats_left - BURST_W'(1);
    end
`else
    assign more = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next state and timer loads: WAIT_CYC on entering ACCESS, TURN_CYC on entering HOLD
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_val  = WAIT_LD;
        case (state)
            IDLE:    state_nxt = req ? SETUP : IDLE;
            SETUP: begin
                state_nxt = ACCESS;
                load      = 1'b1;
            end
            ACCESS: begin
                state_nxt = last ? HOLD : ACCESS;
                load      = last;
                load_val  = TURN_LD;
            end
            HOLD:    state_nxt = last ? (more ? SETUP : IDLE) : HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    // transfer attributes latched at accept; read data captured on the final ACCESS edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            addr    <= '0;
            wdata_q <= '0;
            rdata   <= '0;
        end else begin
            if (accept) begin
                we_q    <= we;
                addr    <= addr_in;
                wdata_q <= wdata;
            end
            if (state == ACCESS && last && !we_q)
                rdata <= dq;
`ifdef SRAM_BUS_CTRL_BURST_EN
            if (state == HOLD && last && more)
                addr <= addr + AW'(1);
            if (ack && we_q && more)
                wdata_q <= wdata;
`endif
        end
    end

    assign ready  = (state == IDLE);
    assign ack    = (state == HOLD) && (count == TURN_LD);
    assign cen    = !(state == SETUP || state == ACCESS);
    assign wen    = !(state == ACCESS && we_q);
    assign oen    = !(state == ACCESS && !we_q);
    assign dq_drv = !cen && we_q;
    assign dq     = dq_drv ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// tb_sram_bus_ctrl: scoreboard bench for sram_bus_ctrl (WAIT_CYC=1 and WAIT_CYC=3 instances)
module tb_sram_bus_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          we;
    logic          sel;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] wdata;
`ifdef SRAM_BUS_CTRL_BURST_EN
    logic [3:0]    burst_len;
`endif

    logic          ready1, ack1, cen1, wen1, oen1;
    logic          ready3, ack3, cen3, wen3, oen3;
    logic [DW-1:0] rdata1, rdata3;
    logic [AW-1:0] addr1, addr3;
    wire  [DW-1:0] dq1, dq3;

    logic [DW-1:0] mem1  [2**AW];
    logic [DW-1:0] mem3  [2**AW];
    logic [DW-1:0] model [2][2**AW];
    logic [DW-1:0] exp_rd [2];
    exp_t          q [$];
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_bus_ctrl #(.DW(DW), .AW(AW), .WAIT_CYC(1), .TURN_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .req(req && !sel), .we(we), .addr_in(addr_in), .wdata(wdata),
`ifdef SRAM_BUS_CTRL_BURST_EN
        .burst_len(burst_len),
`endif
        .ready(ready1), .ack(ack1), .rdata(rdata1), .addr(addr1),
        .cen(cen1), .wen(wen1), .oen(oen1), .dq(dq1)
    );

    sram_bus_ctrl #(.DW(DW), .AW(AW), .WAIT_CYC(3), .TURN_CYC(1)) dut3 (
        .clk(clk), .rst(rst), .req(req && sel), .we(we), .addr_in(addr_in), .wdata(wdata),
`ifdef SRAM_BUS_CTRL_BURST_EN
        .burst_len(4'd0),
`endif
        .ready(ready3), .ack(ack3), .rdata(rdata3), .addr(addr3),
        .cen(cen3), .wen(wen3), .oen(oen3), .dq(dq3)
    );

    // simple SRAM models: drive dq while selected and output-enabled, write while wen low
    assign dq1 = (!cen1 && !oen1) ? mem1[addr1] : 'z;
    assign dq3 = (!cen3 && !oen3) ? mem3[addr3] : 'z;
    always @(posedge clk) if (!cen1 && !wen1) mem1[addr1] <= dq1;
    always @(posedge clk) if (!cen3 && !wen3) mem3[addr3] <= dq3;

    wire           ready_s = sel ? ready3 : ready1;
    wire           ack_s   = sel ? ack3 : ack1;
    wire           wen_s   = sel ? wen3 : wen1;
    wire           oen_s   = sel ? oen3 : oen1;
    wire [DW-1:0]  rdata_s = sel ? rdata3 : rdata1;
    wire [AW-1:0]  addr_s  = sel ? addr3 : addr1;
    wire [DW-1:0]  dq_s    = sel ? dq3 : dq1;

    // continuous strobe safety check on both instances
    initial begin
        forever begin
            @(negedge clk);
            vectors += 2;
            if ((!wen1 && !oen1) || (!oen1 && dut1.dq_drv)) begin
                miscompares++;
                $display("FAIL strobe_excl dut1 cyc=%0d wen=%b oen=%b drv=%b want no overlap", cyc, wen1, oen1, dut1.dq_drv);
            end
            if ((!wen3 && !oen3) || (!oen3 && dut3.dq_drv)) begin
                miscompares++;
                $display("FAIL strobe_excl dut3 cyc=%0d wen=%b oen=%b drv=%b want no overlap", cyc, wen3, oen3, dut3.dq_drv);
            end
        end
    end

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int beats, input bit keep);
        int t = 0;
        int s = sel;
        int wc = sel ? 3 : 1;
        exp_t e;
        while (!ready_s && t < 50) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (!ready_s) begin
            miscompares++;
            $display("FAIL ready_wait got %b want 1", ready_s);
        end
        we = w;
        addr_in = a;
        wdata = d;
        req = 1'b1;
        for (int k = 0; k < beats; k++) begin
            e.w   = w;
            e.a   = a + AW'(k);
            e.d   = w ? d : model[s][a + AW'(k)];
            e.due = cyc + 2 + wc + k * (2 + wc);
            q.push_back(e);
        end
        if (w) model[s][a] = d;
        @(negedge clk);
        if (!keep) req = 1'b0;
        addr_in = AW'($urandom);
        wdata = DW'($urandom);
    endtask

    task automatic wait_acks(input int n);
        int got = 0;
        int t = 0;
        int wl = 0;
        int ol = 0;
        int s = sel;
        int wc = sel ? 3 : 1;
        exp_t e;
        while (got < n && t < 200) begin
            vectors++;
            if (ready_s) begin
                miscompares++;
                $display("FAIL busy_ready cyc=%0d got %b want 0", cyc, ready_s);
            end
            if (q.size() > 0 && !wen_s) begin
                wl++;
                vectors++;
                if (addr_s !== q[0].a || dq_s !== q[0].d) begin
                    miscompares++;
                    $display("FAIL write_bus addr=%h dq=%h want addr=%h dq=%h", addr_s, dq_s, q[0].a, q[0].d);
                end
            end
            if (q.size() > 0 && !oen_s) begin
                ol++;
                vectors++;
                if (addr_s !== q[0].a) begin
                    miscompares++;
                    $display("FAIL read_addr addr=%h want %h", addr_s, q[0].a);
                end
            end
            if (ack_s) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious_ack cyc=%0d got ack want none", cyc);
                end else begin
                    e = q.pop_front();
                    if (cyc !== e.due) begin
                        miscompares++;
                        $display("FAIL ack_latency cyc=%0d want %0d", cyc, e.due);
                    end
                    vectors++;
                    if (addr_s !== e.a) begin
                        miscompares++;
                        $display("FAIL ack_addr got %h want %h", addr_s, e.a);
                    end
                    vectors++;
                    if (!e.w) exp_rd[s] = e.d;
                    if (rdata_s !== exp_rd[s]) begin
                        miscompares++;
                        $display("FAIL rdata got %h want %h", rdata_s, exp_rd[s]);
                    end
                    vectors++;
                    if (wl != (e.w ? wc : 0) || ol != (e.w ? 0 : wc)) begin
                        miscompares++;
                        $display("FAIL strobe_len wen_lo=%0d oen_lo=%0d want %0d/%0d", wl, ol, e.w ? wc : 0, e.w ? 0 : wc);
                    end
                    wl = 0;
                    ol = 0;
                    got++;
                end
            end
            if (got < n) begin
                @(negedge clk);
                t++;
            end
        end
        vectors++;
        if (got < n) begin
            miscompares++;
            $display("FAIL ack_timeout got %0d acks want %0d", got, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        vectors += 8;
        if (ready1 !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", ready1); end
        if (ack1 !== 1'b0) begin miscompares++; $display("FAIL rst_ack got %b want 0", ack1); end
        if (cen1 !== 1'b1) begin miscompares++; $display("FAIL rst_cen got %b want 1", cen1); end
        if (wen1 !== 1'b1) begin miscompares++; $display("FAIL rst_wen got %b want 1", wen1); end
        if (oen1 !== 1'b1) begin miscompares++; $display("FAIL rst_oen got %b want 1", oen1); end
        if (addr1 !== '0) begin miscompares++; $display("FAIL rst_addr got %h want 0", addr1); end
        if (rdata1 !== '0) begin miscompares++; $display("FAIL rst_rdata got %h want 0", rdata1); end
        if (dut1.dq_drv !== 1'b0) begin miscompares++; $display("FAIL rst_dq_drive got %b want 0", dut1.dq_drv); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    task automatic test_write_read();
        sel = 1'b0;
        issue(1'b1, 8'h3C, 8'hA5, 1, 1'b0);
        wait_acks(1);
        issue(1'b0, 8'h3C, 8'h00, 1, 1'b0);
        wait_acks(1);
        vectors++;
        if (mem1[8'h3C] !== 8'hA5) begin
            miscompares++;
            $display("FAIL sram_content got %h want a5", mem1[8'h3C]);
        end
    endtask

    task automatic test_wait3();
        @(negedge clk);
        sel = 1'b1;
        issue(1'b0, 8'h00, 8'h00, 1, 1'b1);
        wait_acks(1);
        @(negedge clk);
        issue(1'b0, 8'h00, 8'h00, 1, 1'b0);
        wait_acks(1);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = AW'($urandom);
            d = DW'($urandom);
            issue(1'b1, a, d, 1, 1'b0);
            wait_acks(1);
            issue(1'b0, a, 8'h00, 1, 1'b0);
            wait_acks(1);
        end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        @(negedge clk);
        sel = 1'b0;
        while (!ready1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        we = 1'b1;
        addr_in = 8'h10;
        wdata = 8'h55;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        vectors++;
        if (wen1 !== 1'b0 || dq1 !== 8'h55 || addr1 !== 8'h10) begin
            miscompares++;
            $display("FAIL mid_access wen=%b dq=%h addr=%h want 0/55/10", wen1, dq1, addr1);
        end
        #2 rst = 1'b0;
        #1;
        vectors += 5;
        if (cen1 !== 1'b1 || wen1 !== 1'b1 || oen1 !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_rst_strobes cen=%b wen=%b oen=%b want 111", cen1, wen1, oen1);
        end
        if (dut1.dq_drv !== 1'b0) begin miscompares++; $display("FAIL mid_rst_dq_drive got %b want 0", dut1.dq_drv); end
        if (ready1 !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready got %b want 1", ready1); end
        if (ack1 !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ack got %b want 0", ack1); end
        if (rdata1 !== '0) begin miscompares++; $display("FAIL mid_rst_rdata got %h want 0", rdata1); end
        @(negedge clk);
        vectors += 2;
        if (ack1 !== 1'b0) begin miscompares++; $display("FAIL mid_rst_no_ack got %b want 0", ack1); end
        if (mem1[8'h10] !== model[0][8'h10]) begin
            miscompares++;
            $display("FAIL mid_rst_sram got %h want %h", mem1[8'h10], model[0][8'h10]);
        end
        rst = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        issue(1'b0, 8'h10, 8'h00, 1, 1'b0);
        wait_acks(1);
    endtask

`ifdef SRAM_BUS_CTRL_BURST_EN
    task automatic test_burst();
        @(negedge clk);
        sel = 1'b0;
        burst_len = 4'd3;
        issue(1'b0, 8'hFE, 8'h00, 4, 1'b0);
        burst_len = 4'd0;
        wait_acks(4);
    endtask
`endif

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            mem1[i] = DW'(i * 37 + 11);
            mem3[i] = DW'(i * 37 + 11);
            model[0][i] = DW'(i * 37 + 11);
            model[1][i] = DW'(i * 37 + 11);
        end
        sel = 1'b0;
        req = 1'b0;
        we = 1'b0;
        addr_in = '0;
        wdata = '0;
`ifdef SRAM_BUS_CTRL_BURST_EN
        burst_len = 4'd0;
`endif
        test_reset();
        test_write_read();
        test_wait3();
        test_back_to_back();
        test_reset_mid();
`ifdef SRAM_BUS_CTRL_BURST_EN
        test_burst();
`endif
        repeat (3) @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover got %0d want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
